// File: rtl/mcm_pkg.sv
// Shared MCM RAM path definitions used by the collector and the packer.
package mcm_pkg;

    localparam int MCM_ADDR_W = 8;
    localparam int MCM_DATA_W = 8;

    localparam logic [MCM_DATA_W-1:0] MCM_SYNC = 8'hA5;
    localparam int MCM_FRAME_MAX = 200;
    localparam int MCM_TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DROP = 3'd4
    } mcm_state_e;

    // A payload length is usable when it is non-zero and fits the RAM frame budget.
    function automatic logic mcm_len_ok(input logic [MCM_DATA_W-1:0] len, input int frame_max);
        return (len != '0) && (int'(len) <= frame_max);
    endfunction

endpackage

// File: rtl/mcm_gap_timer.sv
// Inter-byte gap counter: expires after TIMEOUT enabled cycles with no clear.
module mcm_gap_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Count idle cycles, saturating at the expiry value until the owner stops enabling.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcm_collect.sv
// MCM frame collector: checks framed bytes, writes payload into MCM RAM, hands off to packer.
module mcm_collect
    import mcm_pkg::*;
#(
    parameter logic [MCM_DATA_W-1:0] SYNC      = MCM_SYNC,
    parameter int                    FRAME_MAX = MCM_FRAME_MAX,
    parameter int                    TIMEOUT   = MCM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MCM_DATA_W-1:0] iByte,
    input  logic                  iByteValid,
    input  logic                  iPackBusy,
    output logic [MCM_ADDR_W-1:0] oWrAddr,
    output logic [MCM_DATA_W-1:0] oWrData,
    output logic                  oWrEn,
    output logic [7:0]            oLen,
    output logic                  oDone,
    output logic                  oErr,
    output logic                  oOverrun
);

    mcm_state_e            state_q, state_d;
    logic [7:0]            idx_q, idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            len_q, len_d;
    logic                  drop_len_seen_q, drop_len_seen_d;
    logic                  lock_q, lock_d;
    logic                  busy_prev_q;
    logic [MCM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [MCM_DATA_W-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            len_out_q, len_out_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  overrun_q, overrun_d;

    logic busy_fall;
    logic lock_now;
    logic gap_expired;

    // The gap only matters while a frame (or a dropped frame) is in flight.
    mcm_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (iByteValid || (state_q == ST_IDLE)),
        .enable  (state_q != ST_IDLE),
        .expired (gap_expired)
    );

    // A falling edge of packer busy releases the RAM in the same cycle a SYNC may arrive.
    assign busy_fall = busy_prev_q && !iPackBusy;
    assign lock_now  = lock_q && !busy_fall;

    // Frame parser: next state, RAM write, checksum and handoff pulses.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        sum_d           = sum_q;
        len_d           = len_q;
        drop_len_seen_d = drop_len_seen_q;
        lock_d          = lock_now;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        wr_en_d         = 1'b0;
        len_out_d       = len_out_q;
        done_d          = 1'b0;
        err_d           = 1'b0;
        overrun_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iByteValid && (iByte == SYNC)) begin
                    if (lock_now) begin
                        overrun_d       = 1'b1;
                        drop_len_seen_d = 1'b0;
                        state_d         = ST_DROP;
                    end else begin
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (iByteValid) begin
                    if (!mcm_len_ok(iByte, FRAME_MAX)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = iByte;
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (iByteValid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = iByte;
                    sum_d     = sum_q + iByte;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (iByteValid) begin
                    if (iByte == sum_q) begin
                        len_out_d = len_q;
                        lock_d    = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (iByteValid) begin
                    if (!drop_len_seen_q) begin
                        if (!mcm_len_ok(iByte, FRAME_MAX)) begin
                            state_d = ST_IDLE;
                        end else begin
                            len_d           = iByte;
                            idx_d           = '0;
                            drop_len_seen_d = 1'b1;
                        end
                    end else if (idx_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (gap_expired) begin
            state_d = ST_IDLE;
            if (state_q != ST_DROP) begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any partial frame without announcing it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            sum_q           <= '0;
            len_q           <= '0;
            drop_len_seen_q <= 1'b0;
            lock_q          <= 1'b0;
            busy_prev_q     <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_en_q         <= 1'b0;
            len_out_q       <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            sum_q           <= sum_d;
            len_q           <= len_d;
            drop_len_seen_q <= drop_len_seen_d;
            lock_q          <= lock_d;
            busy_prev_q     <= iPackBusy;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_en_q         <= wr_en_d;
            len_out_q       <= len_out_d;
            done_q          <= done_d;
            err_q           <= err_d;
            overrun_q       <= overrun_d;
        end
    end

    assign oWrAddr  = wr_addr_q;
    assign oWrData  = wr_data_q;
    assign oWrEn    = wr_en_q;
    assign oLen     = len_out_q;
    assign oDone    = done_q;
    assign oErr     = err_q;
    assign oOverrun = overrun_q;

endmodule
